// File: rtl/quadrilatero_row_reader.sv
// Read-port client of the RF sequencer. For each instruction it requests every row of one
// matrix register, tags each request with the instruction ID and streams granted rows out.

package xif_pkg;
    localparam int unsigned X_ID_WIDTH = 4;
endpackage

// state | meaning
// IDLE  | no instruction in flight, instr_ready_o high
// READ  | requesting rows 0..N_ROWS-1 of the latched register
// DRAIN | every row granted, waiting for the final row to leave the FIFO
module quadrilatero_row_reader #(
    parameter int unsigned N_REGS     = 8,
    parameter int unsigned N_ROWS     = 4,
    parameter int unsigned RLEN       = 128,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           instr_valid_i,
    output logic                           instr_ready_o,
    input  logic [$clog2(N_REGS)-1:0]      instr_reg_i,
    input  logic [xif_pkg::X_ID_WIDTH-1:0] instr_id_i,
    output logic [$clog2(N_REGS)-1:0]      raddr_o,
    output logic [$clog2(N_ROWS)-1:0]      rrowaddr_o,
    output logic                           rready_o,
    output logic                           rlast_o,
    output logic [xif_pkg::X_ID_WIDTH-1:0] rd_id_o,
    input  logic [RLEN-1:0]                rdata_i,
    input  logic                           rvalid_i,
    output logic [RLEN-1:0]                data_o,
    output logic [$clog2(N_ROWS)-1:0]      data_row_o,
    output logic                           data_last_o,
    output logic                           data_valid_o,
    input  logic                           data_ready_i,
    output logic                           done_o,
    output logic                           busy_o
);

    localparam int unsigned REG_W = $clog2(N_REGS);
    localparam int unsigned ROW_W = $clog2(N_ROWS);
    localparam int unsigned ID_W  = xif_pkg::X_ID_WIDTH;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [REG_W-1:0] reg_q, reg_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [RLEN-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [RLEN-1:0]  fifo_data_d [FIFO_DEPTH];
    logic [ROW_W-1:0] fifo_row_q  [FIFO_DEPTH];
    logic [ROW_W-1:0] fifo_row_d  [FIFO_DEPTH];
    logic             fifo_last_q [FIFO_DEPTH];
    logic             fifo_last_d [FIFO_DEPTH];

    logic row_is_last;
    logic req;
    logic grant;
    logic head_valid;
    logic pop;
    logic last_pop;

    assign row_is_last = (row_q == LAST_ROW);
    // Request only with a free slot; a pop in the same cycle does not open one early.
    assign req         = (state_q == READ) && (cnt_q < DEPTH);
    assign grant       = req && rvalid_i;
    assign head_valid  = (cnt_q != '0);
    assign pop         = head_valid && data_ready_i;
    assign last_pop    = pop && fifo_last_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        reg_d   = reg_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (instr_valid_i) begin
                    reg_d   = instr_reg_i;
                    id_d    = instr_id_i;
                    row_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (grant) begin
                    if (row_is_last) begin
                        row_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_row_d  = fifo_row_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        if (grant) begin
            fifo_data_d[wr_ptr_q] = rdata_i;
            fifo_row_d[wr_ptr_q]  = row_q;
            fifo_last_d[wr_ptr_q] = row_is_last;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (grant && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!grant && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            row_q    <= '0;
            reg_q    <= '0;
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data_q[i] <= '0;
                fifo_row_q[i]  <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            reg_q       <= reg_d;
            id_q        <= id_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            fifo_data_q <= fifo_data_d;
            fifo_row_q  <= fifo_row_d;
            fifo_last_q <= fifo_last_d;
        end
    end

    assign instr_ready_o = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign rready_o      = req;
    assign rlast_o       = req && row_is_last;
    assign raddr_o       = reg_q;
    assign rrowaddr_o    = row_q;
    assign rd_id_o       = id_q;
    assign data_valid_o  = head_valid;
    assign data_o        = fifo_data_q[rd_ptr_q];
    assign data_row_o    = fifo_row_q[rd_ptr_q];
    assign data_last_o   = fifo_last_q[rd_ptr_q];
    assign done_o        = last_pop;

endmodule

// File: tb/tb_quadrilatero_row_reader.sv
// Bench for quadrilatero_row_reader: random row data and handshakes checked against a
// queue-based model of the instruction/row stream.
module tb_quadrilatero_row_reader;

    localparam int N_REGS     = 8;
    localparam int N_ROWS     = 4;
    localparam int RLEN       = 128;
    localparam int FIFO_DEPTH = 2;
    localparam int RW         = $clog2(N_REGS);
    localparam int ROWW       = $clog2(N_ROWS);
    localparam int IDW        = xif_pkg::X_ID_WIDTH;
    localparam int S_IDLE     = 0;
    localparam int S_READ     = 1;
    localparam int S_DRAIN    = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            instr_valid_i = 1'b0;
    logic            instr_ready_o;
    logic [RW-1:0]   instr_reg_i = '0;
    logic [IDW-1:0]  instr_id_i = '0;
    logic [RW-1:0]   raddr_o;
    logic [ROWW-1:0] rrowaddr_o;
    logic            rready_o;
    logic            rlast_o;
    logic [IDW-1:0]  rd_id_o;
    logic [RLEN-1:0] rdata_i = '0;
    logic            rvalid_i = 1'b0;
    logic [RLEN-1:0] data_o;
    logic [ROWW-1:0] data_row_o;
    logic            data_last_o;
    logic            data_valid_o;
    logic            data_ready_i = 1'b0;
    logic            done_o;
    logic            busy_o;

    always #5 clk_i = ~clk_i;

    quadrilatero_row_reader #(
        .N_REGS(N_REGS), .N_ROWS(N_ROWS), .RLEN(RLEN), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_reg_i(instr_reg_i), .instr_id_i(instr_id_i),
        .raddr_o(raddr_o), .rrowaddr_o(rrowaddr_o), .rready_o(rready_o),
        .rlast_o(rlast_o), .rd_id_o(rd_id_o), .rdata_i(rdata_i), .rvalid_i(rvalid_i),
        .data_o(data_o), .data_row_o(data_row_o), .data_last_o(data_last_o),
        .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
        .done_o(done_o), .busy_o(busy_o)
    );

    typedef struct packed {
        logic [RLEN-1:0] data;
        logic [ROWW-1:0] row;
        logic            last;
    } ent_t;

    int checks = 0;
    int errors = 0;

    // Reference model: instruction phase, next row, latched reg/ID and FIFO contents.
    int   mstate, mrow, mreg, mid;
    ent_t mq[$];

    // Stream-level records: what the model says was granted, what the DUT delivered.
    ent_t exp_stream[$];
    ent_t obs_stream[$];
    int   obs_ids[$];
    int   obs_grants;
    int   done_cycles[$];
    int   gcyc = 0;

    function automatic bit m_rready();
        return (mstate == S_READ) && (mq.size() < FIFO_DEPTH);
    endfunction

    function automatic int first_diff();
        if (obs_stream.size() != exp_stream.size()) return -2;
        foreach (obs_stream[i]) if (obs_stream[i] !== exp_stream[i]) return i;
        return -1;
    endfunction

    function automatic bit stream_order_ok();
        foreach (obs_stream[i]) begin
            if (int'(obs_stream[i].row) != i % N_ROWS) return 1'b0;
            if (obs_stream[i].last != ((i % N_ROWS) == N_ROWS - 1)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        mq.delete();
        mstate = S_IDLE; mrow = 0; mreg = 0; mid = 0;
    endtask

    task automatic clear_obs();
        exp_stream.delete(); obs_stream.delete(); obs_ids.delete(); done_cycles.delete();
        obs_grants = 0;
    endtask

    task automatic drive(input bit vi, input int r, input int id, input bit rv, input bit dr);
        instr_valid_i = vi;
        instr_reg_i   = RW'(r);
        instr_id_i    = IDW'(id);
        rvalid_i      = rv;
        rdata_i       = {$urandom(), $urandom(), $urandom(), $urandom()};
        data_ready_i  = dr;
        #1;
    endtask

    task automatic advance();
        bit   g, p, lp;
        ent_t e, o;
        g  = m_rready() && rvalid_i;
        p  = (mq.size() != 0) && data_ready_i;
        lp = p ? mq[0].last : 1'b0;
        e.data = rdata_i; e.row = ROWW'(mrow); e.last = (mrow == N_ROWS - 1);
        if (g) exp_stream.push_back(e);
        if (rready_o && rvalid_i) begin
            obs_grants++;
            obs_ids.push_back(int'(rd_id_o));
        end
        if (data_valid_o && data_ready_i) begin
            o.data = data_o; o.row = data_row_o; o.last = data_last_o;
            obs_stream.push_back(o);
        end
        if (done_o) done_cycles.push_back(gcyc);
        @(posedge clk_i);
        if (p) void'(mq.pop_front());
        if (g) mq.push_back(e);
        case (mstate)
            S_IDLE: if (instr_valid_i) begin
                mstate = S_READ; mreg = int'(instr_reg_i); mid = int'(instr_id_i); mrow = 0;
            end
            S_READ: if (g) begin
                if (mrow == N_ROWS - 1) begin mstate = S_DRAIN; mrow = 0; end
                else mrow++;
            end
            default: if (lp) mstate = S_IDLE;
        endcase
        gcyc++;
        @(negedge clk_i);
    endtask

    task automatic run_to_idle(input bit rnd, output bit timed_out);
        int n = 0;
        while (mstate != S_IDLE && n < 300) begin
            drive(0, 0, 0, rnd ? 1'($urandom_range(0, 1)) : 1'b1,
                  rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            advance();
            n++;
        end
        timed_out = (mstate != S_IDLE);
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        #1;
        checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_instr_ready: got %b want 1", instr_ready_o); end
        checks++; if ({rready_o, rlast_o, busy_o, done_o, data_valid_o, data_last_o} !== 6'b0) begin errors++;
            $display("FAIL reset_flags: rready=%b rlast=%b busy=%b done=%b dvalid=%b dlast=%b want all 0",
                     rready_o, rlast_o, busy_o, done_o, data_valid_o, data_last_o); end
        checks++; if ({raddr_o, rrowaddr_o, rd_id_o, data_row_o} !== '0 || data_o !== '0) begin errors++;
            $display("FAIL reset_values: raddr=%0d row=%0d id=%0d drow=%0d data=%h want 0",
                     raddr_o, rrowaddr_o, rd_id_o, data_row_o, data_o); end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        int  n = 0;
        bit  exp_last;
        clear_obs();
        drive(1, 3, 5, 1, 1);
        checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL basic_accept: instr_ready=%b want 1", instr_ready_o); end
        advance();
        while (mstate != S_IDLE && n < 30) begin
            drive(0, 0, 0, 1, 1);
            checks++; if (rready_o !== m_rready()) begin errors++; $display("FAIL basic_rready: got %b want %b", rready_o, m_rready()); end
            if (m_rready()) begin
                exp_last = (mrow == N_ROWS - 1);
                checks++;
                if (raddr_o !== 3 || rd_id_o !== 5 || rrowaddr_o !== ROWW'(mrow) || rlast_o !== exp_last) begin
                    errors++;
                    $display("FAIL basic_req: raddr=%0d id=%0d row=%0d rlast=%b want raddr=3 id=5 row=%0d rlast=%b",
                             raddr_o, rd_id_o, rrowaddr_o, rlast_o, mrow, exp_last);
                end
            end
            checks++; if (data_valid_o !== (mq.size() != 0)) begin errors++; $display("FAIL basic_dvalid: got %b want %b", data_valid_o, mq.size() != 0); end
            if (mq.size() != 0) begin
                checks++;
                if (data_o !== mq[0].data || data_row_o !== mq[0].row || data_last_o !== mq[0].last || done_o !== mq[0].last) begin
                    errors++;
                    $display("FAIL basic_head: row=%0d last=%b done=%b want row=%0d last=%b done=%b",
                             data_row_o, data_last_o, done_o, mq[0].row, mq[0].last, mq[0].last);
                end
            end
            advance();
            n++;
        end
        drive(0, 0, 0, 0, 1);
        checks++; if (n >= 30 || instr_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++;
            $display("FAIL basic_idle: cycles=%0d instr_ready=%b busy=%b want <30,1,0", n, instr_ready_o, busy_o); end
        checks++; if (obs_stream.size() != N_ROWS || !stream_order_ok() || first_diff() != -1) begin errors++;
            $display("FAIL basic_stream: got %0d rows (diff at %0d) want %0d in order", obs_stream.size(), first_diff(), N_ROWS); end
        checks++; if (done_cycles.size() != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cycles.size()); end
    endtask

    task automatic test_backpressure();
        int r  = $urandom_range(0, N_REGS - 1);
        int id = $urandom_range(0, (1 << IDW) - 1);
        bit to;
        clear_obs();
        drive(1, r, id, 1, 0);
        advance();
        repeat (6) begin
            drive(0, 0, 0, 1, 0);
            checks++; if (rready_o !== m_rready()) begin errors++; $display("FAIL bp_rready: got %b want %b", rready_o, m_rready()); end
            advance();
        end
        drive(0, 0, 0, 1, 0);
        checks++; if (obs_grants != FIFO_DEPTH || rready_o !== 1'b0) begin errors++;
            $display("FAIL bp_stop: grants=%0d rready=%b want %0d,0", obs_grants, rready_o, FIFO_DEPTH); end
        run_to_idle(1'b0, to);
        checks++; if (to || obs_stream.size() != N_ROWS || !stream_order_ok() || first_diff() != -1) begin errors++;
            $display("FAIL bp_stream: timeout=%b rows=%0d diff=%0d want 0,%0d,-1", to, obs_stream.size(), first_diff(), N_ROWS); end
    endtask

    task automatic test_stall();
        int r  = $urandom_range(0, N_REGS - 1);
        int id = $urandom_range(0, (1 << IDW) - 1);
        bit to;
        clear_obs();
        drive(1, r, id, 1, 1);
        advance();
        drive(0, 0, 0, 1, 1);
        advance();
        repeat (5) begin
            drive(0, 0, 0, 0, 1);
            checks++;
            if (rready_o !== 1'b1 || rrowaddr_o !== 1 || raddr_o !== RW'(r) || rd_id_o !== IDW'(id)) begin
                errors++;
                $display("FAIL stall_req: rready=%b row=%0d raddr=%0d id=%0d want 1,1,%0d,%0d",
                         rready_o, rrowaddr_o, raddr_o, rd_id_o, r, id);
            end
            checks++; if (data_valid_o !== (mq.size() != 0)) begin errors++; $display("FAIL stall_dvalid: got %b want %b", data_valid_o, mq.size() != 0); end
            advance();
        end
        checks++; if (obs_grants != 1) begin errors++; $display("FAIL stall_nopush: grants=%0d want 1", obs_grants); end
        run_to_idle(1'b0, to);
        checks++; if (to || obs_stream.size() != N_ROWS || !stream_order_ok() || first_diff() != -1) begin errors++;
            $display("FAIL stall_stream: timeout=%b rows=%0d diff=%0d want 0,%0d,-1", to, obs_stream.size(), first_diff(), N_ROWS); end
    endtask

    task automatic test_spurious();
        int r  = $urandom_range(0, N_REGS - 1);
        int id = $urandom_range(0, (1 << IDW) - 1);
        bit to;
        clear_obs();
        repeat (3) begin
            drive(0, 0, 0, 1, 1);
            checks++; if (rready_o !== 1'b0 || data_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++;
                $display("FAIL spur_idle: rready=%b dvalid=%b busy=%b want 0,0,0", rready_o, data_valid_o, busy_o); end
            advance();
        end
        drive(1, r, id, 1, 0);
        advance();
        repeat (6) begin
            drive(0, 0, 0, 1, 0);
            checks++; if (rready_o !== m_rready()) begin errors++; $display("FAIL spur_rready: got %b want %b", rready_o, m_rready()); end
            advance();
        end
        drive(0, 0, 0, 1, 0);
        checks++; if (obs_grants != 2 || rrowaddr_o !== 2 || data_row_o !== 0) begin errors++;
            $display("FAIL spur_full: grants=%0d row=%0d head=%0d want 2,2,0", obs_grants, rrowaddr_o, data_row_o); end
        run_to_idle(1'b0, to);
        checks++; if (to || obs_stream.size() != N_ROWS || !stream_order_ok() || first_diff() != -1 || done_cycles.size() != 1) begin errors++;
            $display("FAIL spur_stream: timeout=%b rows=%0d diff=%0d dones=%0d want 0,%0d,-1,1",
                     to, obs_stream.size(), first_diff(), done_cycles.size(), N_ROWS); end
    endtask

    task automatic test_reset_midop();
        int r  = $urandom_range(0, N_REGS - 1);
        int id = $urandom_range(1, (1 << IDW) - 1);
        bit to;
        bit ids_ok = 1'b1;
        clear_obs();
        drive(1, r, id, 1, 1);
        advance();
        repeat (2) begin drive(0, 0, 0, 1, 1); advance(); end
        drive(0, 0, 0, 0, 0);
        checks++; if (data_valid_o !== 1'b1 || data_row_o !== 1 || obs_grants != 2) begin errors++;
            $display("FAIL rst_pre: dvalid=%b head=%0d grants=%0d want 1,1,2", data_valid_o, data_row_o, obs_grants); end
        rst_ni = 1'b0;
        #1;
        checks++; if (instr_ready_o !== 1'b1 || {rready_o, busy_o, done_o, data_valid_o} !== 4'b0 || rd_id_o !== 0 || rrowaddr_o !== 0) begin
            errors++;
            $display("FAIL rst_async: ready=%b rready=%b busy=%b done=%b dvalid=%b id=%0d row=%0d want 1,0,0,0,0,0,0",
                     instr_ready_o, rready_o, busy_o, done_o, data_valid_o, rd_id_o, rrowaddr_o);
        end
        model_reset();
        repeat (2) begin
            @(posedge clk_i); #1;
            checks++; if (done_o !== 1'b0 || data_valid_o !== 1'b0) begin errors++; $display("FAIL rst_hold: done=%b dvalid=%b want 0,0", done_o, data_valid_o); end
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        clear_obs();
        id = $urandom_range(0, (1 << IDW) - 1);
        drive(1, r, id, 1, 1);
        advance();
        run_to_idle(1'b1, to);
        foreach (obs_ids[i]) if (obs_ids[i] != id) ids_ok = 1'b0;
        checks++; if (to || !ids_ok || obs_stream.size() != N_ROWS || !stream_order_ok() || first_diff() != -1 || done_cycles.size() != 1) begin
            errors++;
            $display("FAIL rst_rerun: timeout=%b ids_ok=%b rows=%0d diff=%0d dones=%0d want 0,1,%0d,-1,1",
                     to, ids_ok, obs_stream.size(), first_diff(), done_cycles.size(), N_ROWS);
        end
    endtask

    task automatic test_back_to_back();
        int rA  = $urandom_range(0, N_REGS - 1);
        int rB  = $urandom_range(0, N_REGS - 1);
        int idA = $urandom_range(0, (1 << IDW) - 1);
        int idB = (idA + 1 + $urandom_range(0, (1 << IDW) - 2)) % (1 << IDW);
        int phase = 0;
        int n = 0;
        int acc_cyc = -1;
        bit ids_ok = 1'b1;
        bit rv, dr;
        clear_obs();
        gcyc = 0;
        drive(1, rA, idA, 1, 1);
        advance();
        while (!(phase == 1 && mstate == S_IDLE) && n < 300) begin
            rv = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (phase == 0 && mstate == S_IDLE) begin
                drive(1, rB, idB, rv, dr);
                checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_accept: instr_ready=%b want 1", instr_ready_o); end
                acc_cyc = gcyc;
                phase = 1;
            end else begin
                drive(phase == 0, rB, idB, rv, dr);
                checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_hold: instr_ready=%b want 0 at cycle %0d", instr_ready_o, gcyc); end
                if (m_rready()) begin
                    checks++; if (raddr_o !== RW'(mreg)) begin errors++; $display("FAIL b2b_raddr: got %0d want %0d", raddr_o, mreg); end
                end
            end
            advance();
            n++;
        end
        foreach (obs_ids[i]) if (obs_ids[i] != ((i < N_ROWS) ? idA : idB)) ids_ok = 1'b0;
        checks++; if (done_cycles.size() != 2 || acc_cyc != done_cycles[0] + 1) begin errors++;
            $display("FAIL b2b_timing: dones=%0d accept_cycle=%0d first_done=%0d want 2 dones, accept=first_done+1",
                     done_cycles.size(), acc_cyc, (done_cycles.size() != 0) ? done_cycles[0] : -1); end
        checks++; if (n >= 300 || !ids_ok || obs_ids.size() != 2 * N_ROWS || obs_stream.size() != 2 * N_ROWS
                      || !stream_order_ok() || first_diff() != -1) begin
            errors++;
            $display("FAIL b2b_stream: cycles=%0d ids_ok=%b ids=%0d rows=%0d diff=%0d want <300,1,%0d,%0d,-1",
                     n, ids_ok, obs_ids.size(), obs_stream.size(), first_diff(), 2 * N_ROWS, 2 * N_ROWS);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        clear_obs();
        test_reset();
        test_basic();
        test_backpressure();
        test_stall();
        test_spurious();
        test_reset_midop();
        repeat (3) test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quadrilatero_row_reader.md
Name: quadrilatero_row_reader

Overview:
- Read-port client of the RF sequencer: per accepted instruction, it walks all N_ROWS rows of one matrix register and streams the rows out.
- Issues row read requests tagged with the instruction ID and captures granted data into a small output FIFO.
- The FIFO presents rows as a valid/ready stream to the consuming unit (store path / LSU).
- One instance per sequencer read port; only one instruction is in flight at a time.

Parameters:
N_REGS, 8, number of matrix registers
N_ROWS, 4, rows per register; must be >= 2 and a power of 2
RLEN, 128, row width in bits
FIFO_DEPTH, 2, output FIFO entries; must be >= 1

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
instr_valid_i  in  1  new read instruction valid
instr_ready_o  out  1  block can accept an instruction
instr_reg_i  in  $clog2(N_REGS)  source matrix register
instr_id_i  in  xif_pkg::X_ID_WIDTH  instruction ID
raddr_o  out  $clog2(N_REGS)  register address to sequencer
rrowaddr_o  out  $clog2(N_ROWS)  row address to sequencer
rready_o  out  1  read request to sequencer
rlast_i_n/a: none
rlast_o  out  1  marks request for final row
rd_id_o  out  xif_pkg::X_ID_WIDTH  ID attached to request
rdata_i  in  RLEN  row data from sequencer
rvalid_i  in  1  grant; rdata_i valid this cycle
data_o  out  RLEN  streamed row data
data_row_o  out  $clog2(N_ROWS)  row index of data_o
data_last_o  out  1  data_o is the final row
data_valid_o  out  1  stream valid
data_ready_i  in  1  stream ready
done_o  out  1  one-cycle pulse, instruction complete
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE, row counter=0, latched reg/ID=0, FIFO empty. All outputs are 0 except instr_ready_o=1.
- States: IDLE, READ, DRAIN.
- IDLE:
  - instr_ready_o=1, rready_o=0.
  - On instr_valid_i: latch reg and ID, row=0, go to READ.
- READ:
  - rready_o = (FIFO count < FIFO_DEPTH). There is no same-cycle pop bypass.
  - raddr_o = latched reg, rrowaddr_o = row, rd_id_o = latched ID. These stay constant until the row is granted.
  - rlast_o = rready_o && row==N_ROWS-1.
  - Grant = rvalid_i && rready_o:
    - push {rdata_i, row, row==N_ROWS-1} into the FIFO in the same cycle;
    - if row==N_ROWS-1, go to DRAIN with row=0; otherwise row++.
  - rvalid_i while rready_o=0 is ignored and nothing is pushed.
  - The sequencer may withhold rvalid_i for any number of cycles; the request stays asserted and stable.
- DRAIN:
  - rready_o=0.
  - Leave for IDLE when the last entry pops (data_valid_o && data_ready_i && data_last_o).
- FIFO behaviour:
  - Registered output: row granted at cycle t → data_valid_o=1 at t+1 at the earliest.
  - data_o, data_row_o, data_last_o come from the FIFO head and are held stable while data_valid_o && !data_ready_i.
  - Simultaneous push and pop in one cycle is legal; count is unchanged.
- done_o = data_valid_o && data_ready_i && data_last_o. It is high for exactly one cycle per instruction.
- instr_ready_o is 0 in READ and DRAIN. The next instruction is accepted in the first IDLE cycle, which is the cycle after done_o.
- Row counter wraps only via explicit reset to 0 at the last grant; it never exceeds N_ROWS-1.
- Reset mid-operation: the instruction is abandoned, the FIFO is flushed and no done_o is produced. The sequencer sees rready_o drop immediately; the dispatcher owns clean-up of the scoreboard entry.
- busy_o=1 in READ and DRAIN.

Test Plan:
1. Basic read, N_ROWS=4, data_ready_i=1:
   - Stimulus: instr reg=3, id=5; rvalid_i=1 whenever rready_o.
   - Required: four requests with rrowaddr 0,1,2,3, raddr=3, rd_id=5; rlast_o only on row 3.
   - Required: data_row_o 0..3 each one cycle after its grant; done_o pulses with row 3; back to IDLE.
2. Output backpressure, FIFO_DEPTH=2, data_ready_i=0:
   - Required: after 2 grants, rready_o=0 and no further requests.
   - Release data_ready_i → rows 2,3 are requested; order 0,1,2,3 is preserved with no loss or duplication.
3. Sequencer stall:
   - Stimulus: hold rvalid_i=0 for 5 cycles on row 1.
   - Required: raddr_o, rrowaddr_o=1 and rd_id_o stable with rready_o=1 throughout; no push occurs.
4. Spurious grant:
   - Stimulus: rvalid_i=1 while in IDLE, and while the FIFO is full.
   - Required: no FIFO push, row counter unchanged.
5. Reset mid-op:
   - Stimulus: assert rst_ni=0 after 2 grants with 1 row still in the FIFO.
   - Required: outputs immediately return to reset values, data_valid_o=0, no done_o.
   - Then a new instruction runs from row 0.
6. Back-to-back instructions:
   - Stimulus: second instr_valid_i held high during the first instruction.
   - Required: accepted only in the cycle after done_o; the second stream begins at row 0 with the new ID.
